// File: rtl/strobe_ram.sv
// Byte-strobed 1W/1R RAM with pipelined reads, write-first collision forwarding and a ready FSM.
// Optional macro STROBE_RAM_INIT_CLEAR_EN: zero every word after reset before asserting ready.
module strobe_ram #(
  parameter int    WIDTH    = 32,
  parameter int    DEPTH    = 256,
  parameter int    READ_LAT = 1,
  parameter string DATAFILE = ""
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       write_en,
  input  logic [$clog2(DEPTH)-1:0]   w_addr,
  input  logic [WIDTH/8-1:0]         w_strb,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       r_en,
  input  logic [$clog2(DEPTH)-1:0]   r_addr,
  output logic                       ready,
  output logic                       r_valid,
  output logic [WIDTH-1:0]           data_o
);

  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

`ifdef STROBE_RAM_INIT_CLEAR_EN
  typedef enum logic [1:0] {RST = 2'd0, CLEAR = 2'd1, RUN = 2'd2} state_e;
`else
  typedef enum logic [1:0] {RST = 2'd0, RUN = 2'd2} state_e;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  state_e           state_q, state_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rd_word;
  logic [READ_LAT-1:0] valid_q;
  logic [WIDTH-1:0] data_q [READ_LAT];

  assign ready = (state_q == RUN);
  assign wr_ok = ready && write_en && ({1'b0, w_addr} < DEPTH_W);
  assign rd_ok = ready && r_en;

  // Read word as seen after this edge's write: written lanes forward from data_i.
  always_comb begin
    rd_word = '0;
    if ({1'b0, r_addr} < DEPTH_W) begin
      rd_word = mem[r_addr];
      if (wr_ok && (w_addr == r_addr)) begin
        for (int i = 0; i < NB; i++) begin
          if (w_strb[i]) rd_word[8*i +: 8] = data_i[8*i +: 8];
        end
      end
    end
  end

`ifdef STROBE_RAM_INIT_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clearing;

  assign clearing = (state_q == CLEAR);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      RST: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
`else
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:     state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RST;
    else          state_q <= state_d;
  end
`endif

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
`ifdef STROBE_RAM_INIT_CLEAR_EN
    if (clearing) mem[clr_addr_q] <= '0;
    else
`endif
    if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb[i]) mem[w_addr][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < READ_LAT; k++) data_q[k] <= '0;
    end else begin
      valid_q[0] <= rd_ok;
      if (rd_ok) data_q[0] <= rd_word;
      for (int k = 1; k < READ_LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign r_valid = valid_q[READ_LAT-1];
  assign data_o  = data_q[READ_LAT-1];

endmodule

// File: tb/tb_strobe_ram.sv
// Bench for strobe_ram (DEPTH=200, READ_LAT=3): table vectors, reset sequences and a
// randomised phase, all checked through a read scoreboard against a byte-lane memory model.
module tb_strobe_ram;

  localparam int RL    = 3;
  localparam int DEPTH = 200;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        write_en = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [3:0]  w_strb = '0;
  logic [31:0] data_i = '0;
  logic        r_en = 1'b0;
  logic [7:0]  r_addr = '0;
  logic        ready;
  logic        r_valid;
  logic [31:0] data_o;

  strobe_ram #(.WIDTH(32), .DEPTH(DEPTH), .READ_LAT(RL), .DATAFILE("")) dut (
    .clock(clock), .reset_n(reset_n), .write_en(write_en), .w_addr(w_addr),
    .w_strb(w_strb), .data_i(data_i), .r_en(r_en), .r_addr(r_addr),
    .ready(ready), .r_valid(r_valid), .data_o(data_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sbT;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic [31:0] expData;
  } vecT;

  int          checks = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  logic        expReady = 1'b0;
  logic [31:0] lastExp = '0;
  bit          monOn = 1'b0;
  sbT          sbQ[$];
  sbT          monE;
  logic [31:0] modelMem [DEPTH];
  vecT         vec [25];

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle of requests and records what the RAM owes us.
  task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [3:0] ws,
                               input logic [31:0] wd, input logic re, input logic [7:0] ra,
                               input bit useExp, input logic [31:0] expD);
    sbT          e;
    logic [31:0] w;
    write_en = we; w_addr = wa; w_strb = ws; data_i = wd; r_en = re; r_addr = ra;
    if (expReady && re) begin
      w = '0;
      if (ra < DEPTH) begin
        w = modelMem[ra];
        if (we && (wa == ra)) begin
          for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
        end
      end
      e.data = useExp ? expD : w;
      e.due  = cycleCnt + RL;
      sbQ.push_back(e);
    end
    if (expReady && we && (wa < DEPTH)) begin
      for (int i = 0; i < 4; i++) if (ws[i]) modelMem[wa][8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge clock);
    #1;
    write_en = 1'b0; w_strb = '0; r_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0, 1'b0, 32'h0);
  endtask

  // Reset asserted at posedge+1; the first post-release cycle carries requests that must be dropped.
  task automatic doReset();
    reset_n  = 1'b0;
    expReady = 1'b0;
    sbQ.delete();
    lastExp  = '0;
    #1;
    checkOutput("reset_ready", 32'(ready), 32'h0);
    checkOutput("reset_rvalid", 32'(r_valid), 32'h0);
    checkOutput("reset_data", data_o, 32'h0);
    monOn = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'd0, 4'hF, 32'hBADBAD00, 1'b1, 8'd0, 1'b0, 32'h0);
    expReady = 1'b1;
  endtask

  always @(negedge clock) begin
    if (monOn) begin
      checkOutput("ready", 32'(ready), 32'(expReady));
      if (r_valid) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rvalid got=1 exp=0 data=%h cycle=%0d", data_o, cycleCnt);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("rvalid_cycle", 32'(cycleCnt), 32'(monE.due));
          checkOutput("read_data", data_o, monE.data);
          lastExp = monE.data;
        end
      end else begin
        checkOutput("data_hold", data_o, lastExp);
        if (sbQ.size() > 0 && sbQ[0].due <= cycleCnt) begin
          checks++;
          failures++;
          $display("[TB] FAIL missing_rvalid got=0 exp=1 due=%0d", sbQ[0].due);
          void'(sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec[0]  = '{1'b1, 8'd0,   4'hF, 32'h01020304, 1'b0, 8'd0,   32'h0};
    vec[1]  = '{1'b1, 8'd1,   4'hF, 32'h11121314, 1'b0, 8'd0,   32'h0};
    vec[2]  = '{1'b1, 8'd2,   4'hF, 32'h21222324, 1'b0, 8'd0,   32'h0};
    vec[3]  = '{1'b1, 8'd5,   4'hF, 32'hAABBCCDD, 1'b0, 8'd0,   32'h0};
    vec[4]  = '{1'b1, 8'd5,   4'h5, 32'h11223344, 1'b0, 8'd0,   32'h0};
    vec[5]  = '{1'b1, 8'd7,   4'hF, 32'h00000000, 1'b0, 8'd0,   32'h0};
    vec[6]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hAA22CC44};
    vec[7]  = '{1'b1, 8'd7,   4'h3, 32'hDEADBEEF, 1'b1, 8'd7,   32'h0000BEEF};
    vec[8]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd0,   32'h01020304};
    vec[9]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd1,   32'h11121314};
    vec[10] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd2,   32'h21222324};
    vec[11] = '{1'b1, 8'd250, 4'hF, 32'hFFFFFFFF, 1'b0, 8'd0,   32'h0};
    vec[12] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd250, 32'h0};
    vec[13] = '{1'b1, 8'd9,   4'hF, 32'h12345678, 1'b0, 8'd0,   32'h0};
    vec[14] = '{1'b1, 8'd9,   4'h0, 32'hCAFEF00D, 1'b0, 8'd0,   32'h0};
    vec[15] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd9,   32'h12345678};
    vec[16] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hAA22CC44};
    vec[17] = '{1'b1, 8'd5,   4'hF, 32'hFFFFFFFF, 1'b0, 8'd0,   32'h0};
    vec[18] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hFFFFFFFF};
    vec[19] = '{1'b1, 8'd3,   4'hF, 32'h00000000, 1'b0, 8'd0,   32'h0};
    vec[20] = '{1'b1, 8'd3,   4'h8, 32'h55667788, 1'b0, 8'd0,   32'h0};
    vec[21] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd3,   32'h55000000};
    vec[22] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd200, 32'h0};
    vec[23] = '{1'b1, 8'd199, 4'hF, 32'h99999999, 1'b0, 8'd0,   32'h0};
    vec[24] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 32'h99999999};

    @(posedge clock); #1;
    doReset();

    for (int v = 0; v < 25; v++) begin
      applyStimulus(vec[v].we, vec[v].wa, vec[v].ws, vec[v].wd, vec[v].re, vec[v].ra,
                    1'b1, vec[v].expData);
    end
    idle(RL + 2);

    // A read still in the pipeline when reset hits must never surface.
    applyStimulus(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd5, 1'b0, 32'h0);
    idle(2);
    doReset();
    idle(RL + 2);

    // Contents persist across reset and the write issued before ready was dropped.
    applyStimulus(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd5, 1'b1, 32'hFFFFFFFF);
    applyStimulus(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd0, 1'b1, 32'h01020304);
    idle(RL + 1);

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 8'(a), 4'hF, $urandom, 1'b0, 8'd0, 1'b0, 32'h0);
    end
    for (int n = 0; n < 60; n++) begin
      logic [7:0] wa;
      logic [7:0] ra;
      wa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = wa;
      applyStimulus(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom), ra, 1'b0, 32'h0);
    end
    idle(RL + 3);

    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
